// File: rtl/led_trace_pkg.sv
// Shared definitions for the LED progress-code trace buffer: FSM state
// encoding and the default parameter values used by every file of the block.
package led_trace_pkg;

  // Display mode: LIVE shows the newest code, REPLAY walks the history.
  typedef enum logic {
    LIVE   = 1'b0,
    REPLAY = 1'b1
  } state_t;

  localparam int CODE_W_DEF   = 8;
  localparam int DEPTH_DEF    = 8;
  localparam int TICK_DIV_DEF = 24;

  // Width of a counter able to hold the values 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/led_trace_buffer_if.sv
// Bus between the core-side code writer / replay control and the trace
// buffer. The master drives codes and control, the slave (the buffer)
// returns the displayed code and the history status.
interface led_trace_buffer_if
  import led_trace_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
);

  localparam int CNT_W = count_width(DEPTH);

  logic              code_valid;
  logic [CODE_W-1:0] code_data;
  logic              clr;
  logic              replay;
  logic [CODE_W-1:0] led;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  modport master (
    output code_valid,
    output code_data,
    output clr,
    output replay,
    input  led,
    input  count,
    input  overflow
  );

  modport slave (
    input  code_valid,
    input  code_data,
    input  clr,
    input  replay,
    output led,
    output count,
    output overflow
  );

endinterface

// File: rtl/led_trace_prescaler.sv
// Free-running TICK_DIV-bit prescaler for the replay step rate. While
// enabled it counts every cycle and raises tick for the one cycle in which
// the count sits at its maximum (the count then wraps to 0). clear holds
// the counter at 0 and suppresses tick.
module led_trace_prescaler
  import led_trace_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [TICK_DIV-1:0] CNT_MAX = '1;

  logic [TICK_DIV-1:0] cnt_reg;
  logic [TICK_DIV-1:0] cnt_next;

  // Next count and tick: clear wins, otherwise count while enabled.
  always_comb begin
    cnt_next = cnt_reg;
    tick     = 1'b0;
    if (clear) begin
      cnt_next = '0;
    end else if (enable) begin
      cnt_next = cnt_reg + TICK_DIV'(1);
      tick     = (cnt_reg == CNT_MAX);
    end
  end

  // Counter register, forced to 0 by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/led_trace_buffer.sv
// LED progress-code trace buffer.
// Keeps the last DEPTH progress codes written by the core in a circular
// buffer. In LIVE mode the LEDs show the newest code; in REPLAY mode the
// history is stepped through oldest-first, one entry every 2^TICK_DIV
// cycles, wrapping back to the oldest entry.
// Optional build macro LED_TRACE_DEDUP_EN: when defined, a code equal to
// the newest stored code is dropped instead of being stored again.
module led_trace_buffer
  import led_trace_pkg::*;
#(
  parameter int CODE_W   = CODE_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input logic              clk,
  input logic              rst_n,
  led_trace_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = count_width(DEPTH);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  // History storage; contents are deliberately not reset.
  logic [CODE_W-1:0] mem [DEPTH];

  state_t            state_reg;
  state_t            state_next;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  wr_ptr_next;
  logic [PTR_W-1:0]  rd_base_reg;
  logic [PTR_W-1:0]  rd_base_next;
  logic [PTR_W-1:0]  offset_reg;
  logic [PTR_W-1:0]  offset_next;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic              overflow_reg;
  logic              overflow_next;
  logic [CODE_W-1:0] led_reg;
  logic [CODE_W-1:0] led_next;

  logic              full;
  logic              accept;
  logic              stay_replay;
  logic              tick;
  logic [PTR_W-1:0]  newest_ptr;
  logic [PTR_W-1:0]  rd_addr;
  logic [CODE_W-1:0] newest_code;

  assign full        = (count_reg == FULL_COUNT);
  assign newest_ptr  = wr_ptr_reg - PTR_W'(1);
  assign newest_code = mem[newest_ptr];

`ifdef LED_TRACE_DEDUP_EN
  // Repeats of the newest stored code carry no new progress information.
  assign accept = bus.code_valid &&
                  !((count_reg != '0) && (bus.code_data == newest_code));
`else
  assign accept = bus.code_valid;
`endif

  // The prescaler only runs while the FSM is in REPLAY and stays there;
  // entering or leaving REPLAY restarts it from 0.
  assign stay_replay = (state_reg == REPLAY) && (state_next == REPLAY);

  led_trace_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!stay_replay),
    .enable (stay_replay),
    .tick   (tick)
  );

  // Mode FSM: follows the replay level with one cycle of latency.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LIVE:    if (bus.replay)  state_next = REPLAY;
      REPLAY:  if (!bus.replay) state_next = LIVE;
      default: state_next = LIVE;
    endcase
  end

  // Buffer bookkeeping: clear beats a simultaneous write; a write into a
  // full buffer drops the oldest entry and marks the overflow.
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_base_next  = rd_base_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    if (bus.clr) begin
      wr_ptr_next   = '0;
      rd_base_next  = '0;
      count_next    = '0;
      overflow_next = 1'b0;
    end else if (accept) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (full) begin
        rd_base_next  = rd_base_reg + PTR_W'(1);
        overflow_next = 1'b1;
      end else begin
        count_next = count_reg + CNT_W'(1);
      end
    end
  end

  // Replay offset: relative to the oldest entry, restarted on every entry
  // into REPLAY and on clear; the wrap test uses the post-write count so a
  // write and a step in the same cycle see the grown history.
  always_comb begin
    offset_next = offset_reg;
    if (!stay_replay || bus.clr) begin
      offset_next = '0;
    end else if (tick) begin
      if (({1'b0, offset_reg} + CNT_W'(1)) >= count_next) begin
        offset_next = '0;
      end else begin
        offset_next = offset_reg + PTR_W'(1);
      end
    end
  end

  // Display selection: newest entry in LIVE, oldest+offset in REPLAY,
  // blank when the history is empty or being cleared.
  always_comb begin
    rd_addr  = (state_reg == REPLAY) ? (rd_base_reg + offset_reg) : newest_ptr;
    led_next = mem[rd_addr];
    if (bus.clr || (count_reg == '0)) begin
      led_next = '0;
    end
  end

  // History write port; the slot at wr_ptr is written on an accepted code.
  always_ff @(posedge clk) begin
    if (accept && !bus.clr) begin
      mem[wr_ptr_reg] <= bus.code_data;
    end
  end

  // Control and display registers, all forced idle by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= LIVE;
      wr_ptr_reg   <= '0;
      rd_base_reg  <= '0;
      offset_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      led_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_base_reg  <= rd_base_next;
      offset_reg   <= offset_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      led_reg      <= led_next;
    end
  end

  assign bus.led      = led_reg;
  assign bus.count    = count_reg;
  assign bus.overflow = overflow_reg;

endmodule

// File: tb/tb_led_trace_buffer.sv
// Self-checking bench for led_trace_buffer (DEPTH=4, TICK_DIV=2).
// A queue model of the history produces expectations that are pushed to a
// scoreboard when stimulus is applied and popped when the DUT is sampled.
`timescale 1ns/1ps
module tb_led_trace_buffer;

  localparam int CODE_W   = 8;
  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 2;
  localparam int CNT_W    = $clog2(DEPTH) + 1;
  localparam int STEP     = 1 << TICK_DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  led_trace_buffer_if #(.CODE_W(CODE_W), .DEPTH(DEPTH)) bus ();

  led_trace_buffer #(
    .CODE_W   (CODE_W),
    .DEPTH    (DEPTH),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CODE_W-1:0] led;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;
  } exp_t;

  exp_t              sb_q[$];
  logic [CODE_W-1:0] model_q[$];
  logic              model_ovf = 1'b0;
  int                checks    = 0;
  int                failures  = 0;

  // Reference history: newest at the back, oldest at the front.
  function automatic void model_write(input logic [CODE_W-1:0] c);
`ifdef LED_TRACE_DEDUP_EN
    if (model_q.size() > 0 && model_q[model_q.size()-1] == c) return;
`endif
    model_q.push_back(c);
    if (model_q.size() > DEPTH) begin
      void'(model_q.pop_front());
      model_ovf = 1'b1;
    end
  endfunction

  function automatic void model_clr();
    model_q.delete();
    model_ovf = 1'b0;
  endfunction

  function automatic logic [CODE_W-1:0] model_newest();
    if (model_q.size() == 0) return '0;
    return model_q[model_q.size()-1];
  endfunction

  // Entry on the LEDs i cycles (0-based) after the first replay display edge.
  function automatic logic [CODE_W-1:0] model_replay(input int i);
    if (model_q.size() == 0) return '0;
    return model_q[(i / STEP) % model_q.size()];
  endfunction

  function automatic void expect_state(input logic [CODE_W-1:0] l);
    exp_t e;
    e.led = l;
    e.cnt = CNT_W'(model_q.size());
    e.ovf = model_ovf;
    sb_q.push_back(e);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic [CODE_W-1:0] c);
    bus.code_valid = 1'b1;
    bus.code_data  = c;
    step();
    bus.code_valid = 1'b0;
    model_write(c);
  endtask

  task automatic test_reset();
    exp_t e;
    #1 rst_n = 1'b0;
    #1;
    model_clr();
    expect_state('0);
    e = sb_q.pop_front();
    $display("txn reset led=%h count=%0d overflow=%0b", bus.led, bus.count, bus.overflow);
    checks++; if (bus.led !== e.led) begin failures++; $display("FAIL reset_led got=%h exp=%h", bus.led, e.led); end
    checks++; if (bus.count !== e.cnt) begin failures++; $display("FAIL reset_count got=%0d exp=%0d", bus.count, e.cnt); end
    checks++; if (bus.overflow !== e.ovf) begin failures++; $display("FAIL reset_overflow got=%0b exp=%0b", bus.overflow, e.ovf); end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Single writes in LIVE; also used to push the buffer into overflow.
  task automatic test_live_writes(input string tag, input logic [CODE_W-1:0] codes[$]);
    exp_t e;
    foreach (codes[k]) begin
      drive_write(codes[k]);
      expect_state(model_newest());
      step();
      e = sb_q.pop_front();
      $display("txn %s write=%h led=%h count=%0d overflow=%0b", tag, codes[k], bus.led, bus.count, bus.overflow);
      checks++; if (bus.led !== e.led) begin failures++; $display("FAIL %s_led got=%h exp=%h", tag, bus.led, e.led); end
      checks++; if (bus.count !== e.cnt) begin failures++; $display("FAIL %s_count got=%0d exp=%0d", tag, bus.count, e.cnt); end
      checks++; if (bus.overflow !== e.ovf) begin failures++; $display("FAIL %s_overflow got=%0b exp=%0b", tag, bus.overflow, e.ovf); end
    end
  endtask

  // Enter REPLAY and compare the displayed entry for the given cycles.
  task automatic test_replay(input string tag, input int cycles);
    exp_t e;
    bus.replay = 1'b1;
    step();
    for (int i = 0; i < cycles; i++) begin
      expect_state(model_replay(i));
      step();
      e = sb_q.pop_front();
      $display("txn %s cycle=%0d led=%h", tag, i, bus.led);
      checks++; if (bus.led !== e.led) begin failures++; $display("FAIL %s_led cycle=%0d got=%h exp=%h", tag, i, bus.led, e.led); end
    end
  endtask

  task automatic test_leave_replay(input string tag);
    exp_t e;
    bus.replay = 1'b0;
    step();
    expect_state(model_newest());
    step();
    e = sb_q.pop_front();
    $display("txn %s led=%h count=%0d", tag, bus.led, bus.count);
    checks++; if (bus.led !== e.led) begin failures++; $display("FAIL %s_led got=%h exp=%h", tag, bus.led, e.led); end
    checks++; if (bus.count !== e.cnt) begin failures++; $display("FAIL %s_count got=%0d exp=%0d", tag, bus.count, e.cnt); end
  endtask

  // clr and a write in the same cycle during REPLAY, then an empty replay.
  task automatic test_clr_in_replay();
    exp_t e;
    bus.clr        = 1'b1;
    bus.code_valid = 1'b1;
    bus.code_data  = 8'h2f;
    step();
    bus.clr        = 1'b0;
    bus.code_valid = 1'b0;
    model_clr();
    expect_state('0);
    e = sb_q.pop_front();
    $display("txn clr_replay led=%h count=%0d overflow=%0b", bus.led, bus.count, bus.overflow);
    checks++; if (bus.led !== e.led) begin failures++; $display("FAIL clr_led got=%h exp=%h", bus.led, e.led); end
    checks++; if (bus.count !== e.cnt) begin failures++; $display("FAIL clr_count got=%0d exp=%0d", bus.count, e.cnt); end
    checks++; if (bus.overflow !== e.ovf) begin failures++; $display("FAIL clr_overflow got=%0b exp=%0b", bus.overflow, e.ovf); end
    for (int i = 0; i < 20; i++) begin
      expect_state('0);
      step();
      e = sb_q.pop_front();
      $display("txn empty_replay cycle=%0d led=%h", i, bus.led);
      checks++; if (bus.led !== e.led) begin failures++; $display("FAIL empty_replay_led cycle=%0d got=%h exp=%h", i, bus.led, e.led); end
    end
    drive_write(8'h1e);
    expect_state(8'h1e);
    step();
    e = sb_q.pop_front();
    $display("txn replay_first_write led=%h count=%0d", bus.led, bus.count);
    checks++; if (bus.led !== e.led) begin failures++; $display("FAIL replay_write_led got=%h exp=%h", bus.led, e.led); end
    checks++; if (bus.count !== e.cnt) begin failures++; $display("FAIL replay_write_count got=%0d exp=%0d", bus.count, e.cnt); end
  endtask

  // Consecutive-cycle writes after a clear in LIVE.
  task automatic test_back_to_back(input string tag, input logic [CODE_W-1:0] codes[$]);
    exp_t e;
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    model_clr();
    bus.code_valid = 1'b1;
    foreach (codes[k]) begin
      bus.code_data = codes[k];
      step();
      model_write(codes[k]);
    end
    bus.code_valid = 1'b0;
    expect_state(model_newest());
    step();
    e = sb_q.pop_front();
    $display("txn %s led=%h count=%0d overflow=%0b", tag, bus.led, bus.count, bus.overflow);
    checks++; if (bus.led !== e.led) begin failures++; $display("FAIL %s_led got=%h exp=%h", tag, bus.led, e.led); end
    checks++; if (bus.count !== e.cnt) begin failures++; $display("FAIL %s_count got=%0d exp=%0d", tag, bus.count, e.cnt); end
    checks++; if (bus.overflow !== e.ovf) begin failures++; $display("FAIL %s_overflow got=%0b exp=%0b", tag, bus.overflow, e.ovf); end
  endtask

  task automatic test_dedup();
    logic [CODE_W-1:0] codes[$];
    logic [CNT_W-1:0]  req_cnt;
    codes = '{8'h19, 8'h19, 8'h1a};
    test_back_to_back("dedup", codes);
`ifdef LED_TRACE_DEDUP_EN
    req_cnt = CNT_W'(2);
`else
    req_cnt = CNT_W'(3);
`endif
    checks++; if (bus.count !== req_cnt) begin failures++; $display("FAIL dedup_abs_count got=%0d exp=%0d", bus.count, req_cnt); end
  endtask

  // Reset pulled between clock edges in REPLAY must blank the outputs at once.
  task automatic test_async_reset();
    exp_t e;
    logic [CODE_W-1:0] codes[$];
    codes = '{8'h20, 8'h21, 8'h22};
    test_live_writes("fill", codes);
    bus.replay = 1'b1;
    step();
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    model_clr();
    expect_state('0);
    e = sb_q.pop_front();
    $display("txn async_reset led=%h count=%0d overflow=%0b", bus.led, bus.count, bus.overflow);
    checks++; if (bus.led !== e.led) begin failures++; $display("FAIL areset_led got=%h exp=%h", bus.led, e.led); end
    checks++; if (bus.count !== e.cnt) begin failures++; $display("FAIL areset_count got=%0d exp=%0d", bus.count, e.cnt); end
    checks++; if (bus.overflow !== e.ovf) begin failures++; $display("FAIL areset_overflow got=%0b exp=%0b", bus.overflow, e.ovf); end
    bus.replay = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    codes = '{8'h44};
    test_live_writes("post_reset", codes);
  endtask

  initial begin
    logic [CODE_W-1:0] codes[$];
    bus.code_valid = 1'b0;
    bus.code_data  = '0;
    bus.clr        = 1'b0;
    bus.replay     = 1'b0;
    test_reset();
    codes = '{8'h01, 8'h03, 8'h06};
    test_live_writes("live", codes);
    codes = '{8'h10, 8'h16};
    test_live_writes("overflow", codes);
    test_replay("replay_full", 5 * STEP);
    test_clr_in_replay();
    test_leave_replay("exit_replay");
    codes = '{8'h31, 8'h32, 8'h33};
    test_back_to_back("back_to_back", codes);
    test_replay("replay_part", 6);
    test_leave_replay("replay_abort");
    test_replay("replay_restart", 2 * STEP);
    test_leave_replay("exit_restart");
    test_dedup();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
